// File: rtl/seq_shifter_if.sv
// rtl/seq_shifter_if.sv - request/response bundle for seq_shifter
// Ports (slave view):
//   in_valid, a, amt, mode, out_ready : requester -> shifter
//   in_ready, out_valid, result, err  : shifter -> requester
interface seq_shifter_if #(
    parameter int WIDTH = 24,
    parameter int NW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [NW-1:0]    amt;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output in_valid, a, amt, mode, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, a, amt, mode, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shifter, up to STEP bit positions per clock
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seq_shifter_if.slave (in_valid/in_ready/a/amt/mode request,
//          out_valid/out_ready/result/err response)
// mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN enables ROL; without it
// mode 11 returns a unchanged with err=1 after one cycle.
module seq_shifter #(
    parameter int WIDTH = 24,
    parameter int NW    = 5,
    parameter int STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    seq_shifter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [NW-1:0]    rem;
    logic [1:0]       mode_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             err_r;

    logic [NW-1:0]    step_n;
    logic [WIDTH-1:0] shifted;

    // Positions to move this cycle: min(remaining, STEP).
    always_comb begin
        step_n = rem;
        if (32'(rem) > STEP) begin
            step_n = NW'(STEP);
        end
    end

    // One partial shift of the working register. Repeating partial shifts
    // naturally saturates SLL/SRL to 0 and SRA to sign bits once the total
    // reaches WIDTH, and wraps ROL modulo WIDTH.
    always_comb begin
        shifted = work;
        case (mode_r)
            2'b00:   shifted = work << step_n;
            2'b01:   shifted = work >> step_n;
            2'b10:   shifted = $signed(work) >>> step_n;
`ifdef SEQ_SHIFTER_ROTATE_EN
            2'b11:   shifted = (work << step_n) | (work >> (WIDTH - 32'(step_n)));
`endif
            default: shifted = work;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            work        <= '0;
            rem         <= '0;
            mode_r      <= 2'b00;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work       <= bus.a;
                        rem        <= bus.amt;
                        mode_r     <= bus.mode;
                        err_r      <= 1'b0;
                        in_ready_r <= 1'b0;
`ifndef SEQ_SHIFTER_ROTATE_EN
                        if (bus.mode == 2'b11) begin
                            rem         <= '0;
                            err_r       <= 1'b1;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else
`endif
                        if (bus.amt != '0) begin
                            state <= SHIFT;
                        end else begin
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    rem  <= rem - step_n;
                    if (rem == step_n) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // Accept waits until IDLE is visible, so no back-to-back
                    // accept on the retiring edge.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        err_r       <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = work;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - self-checking bench for seq_shifter
module tb_seq_shifter;
    localparam int W  = 24;
    localparam int NW = 5;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_shifter_if #(.WIDTH(W), .NW(NW)) bus ();

    seq_shifter #(.WIDTH(W), .NW(NW), .STEP(ST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the whole shift in one step from the operation's definition.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] va, input logic [NW-1:0] vamt,
                                               input logic [1:0] vmode);
        longint unsigned mask = (64'd1 << W) - 1;
        longint unsigned x    = 64'(va);
        int              n    = int'(vamt);
        int              r;
        case (vmode)
            2'b00: return (n >= W) ? '0 : W'((x << n) & mask);
            2'b01: return (n >= W) ? '0 : W'(x >> n);
            2'b10: begin
                if (va[W-1]) x = x | ~mask;
                if (n >= W) return va[W-1] ? '1 : '0;
                return W'(x >> n);
            end
            default: begin
`ifdef SEQ_SHIFTER_ROTATE_EN
                r = n % W;
                return W'(((x << r) | (x >> (W - r))) & mask);
`else
                r = 0;
                return va + W'(r);
`endif
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [NW-1:0] vamt, input logic [1:0] vmode);
`ifndef SEQ_SHIFTER_ROTATE_EN
        if (vmode == 2'b11) return 1;
`endif
        return 1 + (int'(vamt) + ST - 1) / ST;
    endfunction

    function automatic logic ref_err(input logic [1:0] vmode);
`ifdef SEQ_SHIFTER_ROTATE_EN
        return 1'b0 & vmode[0];
`else
        return vmode == 2'b11;
`endif
    endfunction

    // Transaction-level model: 0 idle, 1 busy, 2 result pending.
    int           m_state = 0;
    int           m_left  = 0;
    logic [W-1:0] m_res   = '0;
    logic         m_err   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0;
        end else begin
            case (m_state)
                0: if (bus.in_valid) begin
                    m_res  = ref_shift(bus.a, bus.amt, bus.mode);
                    m_err  = ref_err(bus.mode);
                    m_left = ref_lat(bus.amt, bus.mode) - 1;
                    m_state = (m_left == 0) ? 2 : 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_state = 2;
                end
                default: if (bus.out_ready) m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_result", 32'(bus.result), 32'h0);
            check("rst_in_ready", 32'(bus.in_ready), 32'h1);
            check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        end else begin
            check("mon_in_ready", 32'(bus.in_ready), 32'(m_state == 0));
            check("mon_out_valid", 32'(bus.out_valid), 32'(m_state == 2));
            if (m_state == 2) begin
                check("mon_result", 32'(bus.result), 32'(m_res));
                check("mon_err", 32'(bus.err), 32'(m_err));
            end
        end
    end

    task automatic run(input logic [W-1:0] va, input logic [NW-1:0] vamt, input logic [1:0] vmode,
                       input logic [W-1:0] er, input logic ee, input int el,
                       input int stall, input bit hold, input string nm);
        int lat;
        bit got;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = va;
        bus.amt       = vamt;
        bus.mode      = vmode;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        // Scramble the operands after capture; the result must not notice.
        bus.a    = ~va;
        bus.amt  = vamt ^ 5'h1f;
        bus.mode = ~vmode;
        if (!hold) bus.in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        while (lat < 40 && !got) begin
            if (bus.out_valid) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        bus.in_valid = 1'b0;
        check({nm, "_lat"}, 32'(lat), 32'(el));
        check({nm, "_result"}, 32'(bus.result), 32'(er));
        check({nm, "_err"}, 32'(bus.err), 32'(ee));
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            check({nm, "_stall_result"}, 32'(bus.result), 32'(er));
            check({nm, "_stall_in_ready"}, 32'(bus.in_ready), 32'h0);
            check({nm, "_stall_out_valid"}, 32'(bus.out_valid), 32'h1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({nm, "_ret_in_ready"}, 32'(bus.in_ready), 32'h1);
        check({nm, "_ret_out_valid"}, 32'(bus.out_valid), 32'h0);
    endtask

    initial begin
        bit seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.amt       = '0;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b0;
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'h1);
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_result", 32'(bus.result), 32'h0);
        check("reset_err", 32'(bus.err), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        run(24'h000001, 5'd5,  2'b00, 24'h000020, 1'b0, 3, 0, 1'b0, "sll_1_5");
        run(24'h800000, 5'd4,  2'b10, 24'hF80000, 1'b0, 2, 0, 1'b0, "sra_neg_4");
        run(24'hFFFFFF, 5'd31, 2'b01, 24'h000000, 1'b0, 9, 0, 1'b1, "srl_31_hold");
`ifdef SEQ_SHIFTER_ROTATE_EN
        run(24'h800001, 5'd1,  2'b11, 24'h000003, 1'b0, 2, 0, 1'b0, "rol_1");
        run(24'h123456, 5'd8,  2'b11, 24'h345612, 1'b0, 3, 0, 1'b0, "rol_8");
        run(24'hABCDEF, 5'd28, 2'b11, 24'hBCDEFA, 1'b0, 8, 0, 1'b0, "rol_28");
`else
        run(24'h800001, 5'd1,  2'b11, 24'h800001, 1'b1, 1, 0, 1'b0, "rol_off_1");
        run(24'h123456, 5'd8,  2'b11, 24'h123456, 1'b1, 1, 0, 1'b0, "rol_off_8");
`endif
        run(24'h123456, 5'd0,  2'b01, 24'h123456, 1'b0, 1, 0, 1'b1, "srl_0");
        run(24'h000001, 5'd23, 2'b00, 24'h800000, 1'b0, 7, 0, 1'b0, "sll_23");
        run(24'hFFFFFF, 5'd24, 2'b00, 24'h000000, 1'b0, 7, 0, 1'b0, "sll_24");
        run(24'h7FFFFF, 5'd30, 2'b10, 24'h000000, 1'b0, 9, 0, 1'b0, "sra_pos_30");
        run(24'h800000, 5'd24, 2'b10, 24'hFFFFFF, 1'b0, 7, 0, 1'b0, "sra_neg_24");
        run(24'h900000, 5'd6,  2'b10, 24'hFE4000, 1'b0, 3, 0, 1'b0, "sra_neg_6");
        run(24'hF00000, 5'd3,  2'b01, 24'h1E0000, 1'b0, 2, 5, 1'b0, "srl_3_stall");

        // Reset in the middle of a long SHIFT.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 24'hABCDEF;
        bus.amt      = 5'd20;
        bus.mode     = 2'b00;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'h1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_result", 32'(bus.result), 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrst_no_out_valid", 32'(seen), 32'h0);

        run(24'h000001, 5'd5,  2'b00, 24'h000020, 1'b0, 3, 0, 1'b0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
